// File: rtl/cfu_mac_seq.sv
// Sequencer between the CPU CFU port and the 8-lane SIMD MAC: operand-pair FIFO,
// group engine (load-lo/load-hi/accumulate) and CPU command decode. Build with
// CFU_MAC_SEQ_STATS_EN defined to add the op-4 stall counter.
module cfu_mac_seq #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic        mac_cmd_valid,
  input  logic        mac_cmd_ready,
  output logic [9:0]  mac_func_id,
  output logic [31:0] mac_in0,
  output logic [31:0] mac_in1,
  input  logic        mac_rsp_valid,
  output logic        mac_rsp_ready,
  input  logic [31:0] mac_rsp_out
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [6:0] OP_CFG   = 7'd0;
  localparam logic [6:0] OP_PUSH  = 7'd1;
  localparam logic [6:0] OP_RES   = 7'd2;
  localparam logic [6:0] OP_STAT  = 7'd3;
  localparam logic [6:0] OP_STATS = 7'd4;

  localparam logic [9:0] MF_CFG = 10'd8;
  localparam logic [9:0] MF_LO  = 10'd16;
  localparam logic [9:0] MF_HI  = 10'd24;
  localparam logic [9:0] MF_ACC = 10'd32;

  typedef enum logic [2:0] {
    E_IDLE = 3'd0, E_LO = 3'd1, E_WLO = 3'd2, E_HI = 3'd3,
    E_WHI = 3'd4, E_ACC = 3'd5, E_WACC = 3'd6
  } eng_e;

  typedef enum logic [2:0] {U_IDLE, U_CFG, U_CFGW, U_RES, U_RSP} up_e;

  eng_e             eng_q;
  up_e              up_q;
  logic             cmd_ready_q, rsp_valid_q;
  logic [31:0]      rsp_data_q;
  logic [15:0]      cfg_off_q;
  logic [CNT_W-1:0] cfg_n_q, nrem_q;
  logic [31:0]      acc_q;
  logic             mac_vld_q, mac_rsp_rdy_q;
  logic [9:0]       mac_func_q;
  logic [31:0]      mac_in0_q, mac_in1_q;

  logic [63:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic [63:0]      head;

  logic [6:0]  op;
  logic        accept, full, push, pop, flush;
  logic        cfg_pend, cfg_go, cnt_ge2, nrem_nz, start, more, res_ok;
  logic        mcmd_hs, mrsp_hs;
  logic [31:0] status;

  assign op       = cmd_payload_function_id[9:3];
  assign accept   = cmd_valid && cmd_ready_q;
  assign full     = (cnt_q == FULL_CNT);
  assign push     = accept && (op == OP_PUSH) && !full;
  assign head     = mem_q[rp_q];
  assign cnt_ge2  = (cnt_q >= (AW+1)'(2));
  assign nrem_nz  = (nrem_q != '0);
  assign cfg_pend = (up_q == U_CFG) || (up_q == U_CFGW);
  assign cfg_go   = (up_q == U_CFG) && (eng_q == E_IDLE);
  assign flush    = cfg_go;
  assign mcmd_hs  = mac_vld_q && mac_cmd_ready;
  assign mrsp_hs  = mac_rsp_rdy_q && mac_rsp_valid;
  assign start    = (eng_q == E_IDLE) && nrem_nz && cnt_ge2 && !cfg_pend;
  // Continue straight into the next group only if one remains after this decrement.
  assign more     = (nrem_q > CNT_W'(1)) && cnt_ge2 && !cfg_pend;
  assign pop      = start || ((eng_q == E_WLO) && mrsp_hs)
                          || ((eng_q == E_WACC) && mrsp_hs && more);
  assign res_ok   = (eng_q == E_IDLE) && (!nrem_nz || !cnt_ge2);
  assign status   = {16'(nrem_q), 8'(cnt_q), 5'b0, eng_q};

  // Operand-pair FIFO; {in0,in1} per entry
  always_comb begin
    cnt_d = cnt_q;
    if (flush) cnt_d = '0;
    else       cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (flush) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (push) wp_q <= wp_q + AW'(1);
        if (pop)  rp_q <= rp_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {cmd_payload_inputs_0, cmd_payload_inputs_1};
  end

  // Group engine; also owns the MAC port registers, which CFG borrows while engine is idle
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_q         <= E_IDLE;
      nrem_q        <= '0;
      acc_q         <= '0;
      mac_vld_q     <= 1'b0;
      mac_rsp_rdy_q <= 1'b0;
      mac_func_q    <= '0;
      mac_in0_q     <= '0;
      mac_in1_q     <= '0;
    end else begin
      case (eng_q)
        E_IDLE: begin
          if (mcmd_hs) begin
            mac_vld_q     <= 1'b0;
            mac_rsp_rdy_q <= 1'b1;
          end
          if (mrsp_hs) mac_rsp_rdy_q <= 1'b0;
          if (cfg_go) begin
            nrem_q     <= cfg_n_q;
            acc_q      <= '0;
            mac_vld_q  <= 1'b1;
            mac_func_q <= MF_CFG;
            mac_in0_q  <= {16'b0, cfg_off_q};
            mac_in1_q  <= '0;
          end else if (start) begin
            eng_q      <= E_LO;
            mac_vld_q  <= 1'b1;
            mac_func_q <= MF_LO;
            mac_in0_q  <= head[63:32];
            mac_in1_q  <= head[31:0];
          end
        end
        E_LO, E_HI, E_ACC: begin
          if (mac_cmd_ready) begin
            mac_vld_q     <= 1'b0;
            mac_rsp_rdy_q <= 1'b1;
            eng_q         <= eng_e'(eng_q + 3'd1);
          end
        end
        E_WLO: begin
          if (mrsp_hs) begin
            mac_rsp_rdy_q <= 1'b0;
            eng_q         <= E_HI;
            mac_vld_q     <= 1'b1;
            mac_func_q    <= MF_HI;
            mac_in0_q     <= head[63:32];
            mac_in1_q     <= head[31:0];
          end
        end
        E_WHI: begin
          if (mrsp_hs) begin
            mac_rsp_rdy_q <= 1'b0;
            eng_q         <= E_ACC;
            mac_vld_q     <= 1'b1;
            mac_func_q    <= MF_ACC;
            mac_in0_q     <= '0;
            mac_in1_q     <= '0;
          end
        end
        E_WACC: begin
          if (mrsp_hs) begin
            mac_rsp_rdy_q <= 1'b0;
            acc_q         <= mac_rsp_out;
            nrem_q        <= nrem_q - CNT_W'(1);
            if (more) begin
              eng_q      <= E_LO;
              mac_vld_q  <= 1'b1;
              mac_func_q <= MF_LO;
              mac_in0_q  <= head[63:32];
              mac_in1_q  <= head[31:0];
            end else begin
              eng_q <= E_IDLE;
            end
          end
        end
        default: eng_q <= E_IDLE;
      endcase
    end
  end

`ifdef CFU_MAC_SEQ_STATS_EN
  logic [31:0] stall_q;
  logic        stall;

  always_comb begin
    stall = 1'b0;
    case (eng_q)
      E_IDLE:            stall = nrem_nz && !cnt_ge2;
      E_LO, E_HI, E_ACC: stall = !mcmd_hs;
      default:           stall = !mrsp_hs;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || cfg_go) stall_q <= '0;
    else if (stall)      stall_q <= stall_q + 32'd1;
  end
`endif

  // CPU side: one outstanding command, response held until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      up_q        <= U_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cfg_off_q   <= '0;
      cfg_n_q     <= '0;
    end else begin
      case (up_q)
        U_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            up_q        <= U_RSP;
            case (op)
              OP_CFG: begin
                rsp_valid_q <= 1'b0;
                cfg_off_q   <= cmd_payload_inputs_0[15:0];
                cfg_n_q     <= cmd_payload_inputs_1[CNT_W-1:0];
                up_q        <= U_CFG;
              end
              OP_PUSH: rsp_data_q <= {full, 23'b0, 8'(cnt_d)};
              OP_RES: begin
                rsp_valid_q <= 1'b0;
                up_q        <= U_RES;
              end
              OP_STAT: rsp_data_q <= status;
`ifdef CFU_MAC_SEQ_STATS_EN
              OP_STATS: rsp_data_q <= stall_q;
`endif
              default: ;
            endcase
          end
        end
        U_CFG: if (cfg_go) up_q <= U_CFGW;
        U_CFGW: begin
          if (mrsp_hs) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            up_q        <= U_RSP;
          end
        end
        U_RES: begin
          if (res_ok) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= acc_q;
            up_q        <= U_RSP;
          end
        end
        U_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            up_q        <= U_IDLE;
          end
        end
        default: up_q <= U_IDLE;
      endcase
    end
  end

  assign cmd_ready             = cmd_ready_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;
  assign mac_cmd_valid         = mac_vld_q;
  assign mac_func_id           = mac_func_q;
  assign mac_in0               = mac_in0_q;
  assign mac_in1               = mac_in1_q;
  assign mac_rsp_ready         = mac_rsp_rdy_q;

endmodule

// File: tb/tb_cfu_mac_seq.sv
// Directed bench for cfu_mac_seq with a behavioural 8-lane MAC on the MAC port.
// Honours CFU_MAC_SEQ_STATS_EN for the op-4 expectation.
module tb_cfu_mac_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  fid = '0;
  logic [31:0] in0 = '0, in1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_out;
  logic        mac_cmd_valid;
  logic        mac_cmd_ready = 1'b1;
  logic [9:0]  mac_func_id;
  logic [31:0] mac_in0, mac_in1;
  logic        mac_rsp_valid = 1'b0;
  logic        mac_rsp_ready;
  logic [31:0] mac_rsp_out = '0;

  always #5 clk = ~clk;

  cfu_mac_seq dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(fid),
    .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_out),
    .mac_cmd_valid(mac_cmd_valid), .mac_cmd_ready(mac_cmd_ready),
    .mac_func_id(mac_func_id), .mac_in0(mac_in0), .mac_in1(mac_in1),
    .mac_rsp_valid(mac_rsp_valid), .mac_rsp_ready(mac_rsp_ready), .mac_rsp_out(mac_rsp_out)
  );

  // Behavioural MAC: lane i = (signed a_i + offset) * signed b_i, summed into acc
  int          mac_lat = 0;
  int          n_lo = 0, n_hi = 0;
  logic        m_pend = 1'b0;
  int          m_lat = 0;
  logic [31:0] m_acc = '0, m_off = '0, lo_a = '0, lo_b = '0, hi_a = '0, hi_b = '0;

  function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] off);
    int  s;
    byte av, bv;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      av = a[8*i +: 8];
      bv = b[8*i +: 8];
      s += (int'(av) + int'(off)) * int'(bv);
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mac_rsp_valid <= 1'b0;
      mac_rsp_out   <= '0;
      m_pend        <= 1'b0;
      m_lat         <= 0;
      m_acc         <= '0;
    end else begin
      if (mac_rsp_valid && mac_rsp_ready) mac_rsp_valid <= 1'b0;
      if (mac_cmd_valid && mac_cmd_ready) begin
        m_pend <= 1'b1;
        m_lat  <= mac_lat;
        case (mac_func_id[9:3])
          7'd1: begin m_off <= mac_in0; m_acc <= '0; end
          7'd2: begin lo_a <= mac_in0; lo_b <= mac_in1; n_lo <= n_lo + 1; end
          7'd3: begin hi_a <= mac_in0; hi_b <= mac_in1; n_hi <= n_hi + 1; end
          7'd4: m_acc <= m_acc + dot4(lo_a, lo_b, m_off) + dot4(hi_a, hi_b, m_off);
          default: ;
        endcase
      end else if (m_pend) begin
        if (m_lat == 0) begin
          mac_rsp_valid <= 1'b1;
          mac_rsp_out   <= m_acc;
          m_pend        <= 1'b0;
        end else begin
          m_lat <= m_lat - 1;
        end
      end
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One CPU transaction; called at a negedge, returns at a negedge
  task automatic cpu(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] r);
    int t;
    r = 32'hDEAD_BEEF;
    t = 0;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      n_vec++; n_err++;
      $display("FAIL cmd_timeout op=%0d: got no cmd_ready, expected it within 200 cycles", op);
      return;
    end
    cmd_valid = 1'b1; fid = {op, 3'b000}; in0 = a; in1 = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 2000) begin @(negedge clk); t++; end
    if (!rsp_valid) begin
      n_vec++; n_err++;
      $display("FAIL rsp_timeout op=%0d: got no rsp_valid, expected it within 2000 cycles", op);
      return;
    end
    r = rsp_out;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [31:0] a, b, exp, mask;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] F = 32'hFFFF_FFFF;
  localparam logic [31:0] D = 32'h8000_0000;  // push count timing-dependent: check drop bit only
  localparam logic [31:0] P = 32'h0101_0101;

  task automatic add(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input logic [31:0] mask);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.mask = mask;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected one before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, f0, a0, b0;
    logic        stable;
    int          lo0, hi0, t;

    // Group A: one group, 8 lanes x 128 x 1
    add(0, 128, 1, 0, F); add(1, 0, P, 1, F); add(1, 0, P, 2, F);
    add(2, 0, 0, 32'd1024, F); add(3, 0, 0, 0, F);
    // Group B: two groups
    add(0, 128, 2, 0, F);
    for (int i = 0; i < 4; i++) add(1, 0, P, 0, D);
    add(2, 0, 0, 32'd2048, F); add(3, 0, 0, 0, F);
    // Group C: fill FIFO with N=0, ninth push dropped
    add(0, 0, 0, 0, F);
    for (int i = 1; i <= 8; i++) add(1, i, i, i, F);
    add(1, 9, 9, 32'h8000_0008, F); add(3, 0, 0, 32'h0000_0800, F);
    // Group D: starvation, RESULT must still return; unknown ops change nothing
    add(0, 128, 2, 0, F);
    for (int i = 0; i < 3; i++) add(1, 0, P, 0, D);
    add(2, 0, 0, 32'd1024, F); add(3, 0, 0, 32'h0001_0100, F);
    add(5, 0, 0, 0, F); add(7'd100, 32'hFFFF, 32'hFFFF, 0, F); add(3, 0, 0, 32'h0001_0100, F);
    // Group E: signed-lane arithmetic with offset 1: (4+3+2+1+4)*1 + (8+7+6+5+4)*2 = 74
    add(0, 1, 1, 0, F); add(1, 32'h0102_0304, P, 1, F);
    add(1, 32'h0506_0708, 32'h0202_0202, 2, F); add(2, 0, 0, 32'd74, F);

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_data", rsp_out, 0);
    chk("rst_mac_flags", {30'b0, mac_cmd_valid, mac_rsp_ready}, 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      cpu(tbl[i].op, tbl[i].a, tbl[i].b, r);
      chk($sformatf("vec%0d_op%0d", i, tbl[i].op), r & tbl[i].mask, tbl[i].exp & tbl[i].mask);
    end

    // MAC back-pressure during LO: payload held, one command issued, result unchanged
    cpu(0, 128, 1, r); chk("stall_cfg", r, 0);
    mac_cmd_ready = 1'b0;
    lo0 = n_lo;
    cpu(1, 0, P, r); chk("stall_push1", r, 1);
    cpu(1, 0, P, r); chk("stall_push2", r, 2);
    t = 0;
    while (!mac_cmd_valid && t < 50) begin @(negedge clk); t++; end
    chk("stall_func", {22'b0, mac_func_id}, 32'h10);
    chk("stall_in1", mac_in1, P);
    f0 = {22'b0, mac_func_id}; a0 = mac_in0; b0 = mac_in1;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(mac_cmd_valid && {22'b0, mac_func_id} == f0 && mac_in0 == a0 && mac_in1 == b0))
        stable = 1'b0;
    end
    chk("stall_stable", {31'b0, stable}, 1);
    mac_cmd_ready = 1'b1;
    cpu(2, 0, 0, r); chk("stall_result", r, 32'd1024);
    chk("stall_lo_cmds", n_lo - lo0, 1);
    cpu(4, 0, 0, r);
`ifdef CFU_MAC_SEQ_STATS_EN
    chk("stats_ge5", {31'b0, (r >= 32'd5)}, 1);
`else
    chk("op4_unknown", r, 0);
`endif

    // Reset while waiting on the load-hi response
    mac_lat = 3;
    cpu(0, 128, 1, r); chk("whi_cfg", r, 0);
    hi0 = n_hi;
    cpu(1, 0, P, r);
    cpu(1, 0, P, r);
    t = 0;
    while (n_hi == hi0 && t < 100) begin @(negedge clk); t++; end
    chk("whi_reached", n_hi - hi0, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_flags", {28'b0, cmd_ready, rsp_valid, mac_cmd_valid, mac_rsp_ready}, 0);
    chk("rst2_rsp_data", rsp_out, 0);
    chk("rst2_mac_func", {22'b0, mac_func_id}, 0);
    chk("rst2_mac_in", mac_in0 | mac_in1, 0);
    reset = 1'b0;
    mac_lat = 0;
    @(negedge clk);
    cpu(3, 0, 0, r); chk("rst2_status", r, 0);
    cpu(2, 0, 0, r); chk("rst2_result", r, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
